// File: rtl/nb_pipe_pkg.sv
// nb_pipe_pkg: shared constants, FSM state type and helpers for the four-stage pipe sequencer.
package nb_pipe_pkg;
    localparam int NSTAGE    = 4;
    localparam int W_DEF     = 32;
    localparam int CNT_W_DEF = 16;

    typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, STREAM = 2'd2} seq_state_t;

    function automatic logic [2:0] popcount4(input logic [3:0] v);
        return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
    endfunction
endpackage

// File: rtl/nb_pipe_stage.sv
// nb_pipe_stage: one data register plus valid flop; data loads only when the upstream word is valid.
module nb_pipe_stage
    import nb_pipe_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic         clock_i,
    input  logic         reset_n_i,
    input  logic         load_en_i,
    input  logic         clr_i,
    input  logic         up_valid_i,
    input  logic [W-1:0] up_data_i,
    output logic         valid_o,
    output logic [W-1:0] data_o
);
    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;

    always_comb begin
        valid_d = clr_i ? 1'b0 : load_en_i ? up_valid_i : valid_q;
        data_d  = (load_en_i & up_valid_i & ~clr_i) ? up_data_i : data_q;
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
endmodule

// File: rtl/nb_pipe_sequencer.sv
// nb_pipe_sequencer: valid/ready controller for the a->b->c->d register chain with flush,
// occupancy, FSM state and a saturating stall-cycle counter.
module nb_pipe_sequencer
    import nb_pipe_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clock_i,
    input  logic             reset_n_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [W-1:0]     in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [W-1:0]     out_data_o,
    input  logic             flush_i,
    output logic [W-1:0]     a_o,
    output logic [W-1:0]     b_o,
    output logic [W-1:0]     c_o,
    output logic [W-1:0]     d_o,
    output logic [2:0]       occupancy_o,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cnt_o
);
    logic [NSTAGE-1:0] v;
    logic [NSTAGE:0]   uv;
    logic [W-1:0]      ud [NSTAGE+1];
    logic [NSTAGE-1:0] nv;
    logic              advance;
    seq_state_t        state_q, state_d;
    logic [CNT_W-1:0]  stall_q, stall_d;

    assign advance = ~flush_i & ~(v[NSTAGE-1] & ~out_ready_i);
    assign uv      = {v, in_valid_i};
    assign ud[0]   = in_data_i;

    for (genvar i = 0; i < NSTAGE; i++) begin : g_stage
        nb_pipe_stage #(.W(W)) u_stage (
            .clock_i    (clock_i),
            .reset_n_i  (reset_n_i),
            .load_en_i  (advance),
            .clr_i      (flush_i),
            .up_valid_i (uv[i]),
            .up_data_i  (ud[i]),
            .valid_o    (v[i]),
            .data_o     (ud[i+1])
        );
    end

    // FSM looks ahead at the valid bits the coming edge will produce
    always_comb begin
        nv      = flush_i ? '0 : advance ? uv[NSTAGE-1:0] : v;
        state_d = (flush_i || nv == '0) ? IDLE : nv[NSTAGE-1] ? STREAM : FILL;
        stall_d = (v[NSTAGE-1] & ~out_ready_i & ~flush_i & ~&stall_q) ? stall_q + 1'b1 : stall_q;
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= IDLE;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            stall_q <= stall_d;
        end
    end

    assign in_ready_o  = advance & reset_n_i;
    assign out_valid_o = v[NSTAGE-1];
    assign out_data_o  = ud[NSTAGE];
    assign a_o         = ud[1];
    assign b_o         = ud[2];
    assign c_o         = ud[3];
    assign d_o         = ud[4];
    assign occupancy_o = popcount4(v);
    assign state_o     = state_q;
    assign stall_cnt_o = stall_q;
endmodule

// File: tb/tb_nb_pipe_sequencer.sv
// tb_nb_pipe_sequencer: table-driven vectors for fill/stream/stall/bubble/flush plus
// hand-written async-reset and counter-saturation sequences.
module tb_nb_pipe_sequencer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, iv, ordy, fl;
    logic [31:0] din;
    logic        ir, ov;
    logic [31:0] od, a, b, c, d;
    logic [2:0]  occ;
    logic [1:0]  st;
    logic [15:0] sc;

    logic        s_iv, s_ordy, s_ir, s_ov;
    logic [31:0] s_din, s_od, s_a, s_b, s_c, s_d;
    logic [2:0]  s_occ;
    logic [1:0]  s_st;
    logic [3:0]  s_sc;

    int checks = 0;
    int errors = 0;

    nb_pipe_sequencer dut (
        .clock_i(clk), .reset_n_i(rst_n), .in_valid_i(iv), .in_ready_o(ir), .in_data_i(din),
        .out_valid_o(ov), .out_ready_i(ordy), .out_data_o(od), .flush_i(fl),
        .a_o(a), .b_o(b), .c_o(c), .d_o(d), .occupancy_o(occ), .state_o(st), .stall_cnt_o(sc)
    );

    nb_pipe_sequencer #(.W(32), .CNT_W(4)) u_sat (
        .clock_i(clk), .reset_n_i(rst_n), .in_valid_i(s_iv), .in_ready_o(s_ir), .in_data_i(s_din),
        .out_valid_o(s_ov), .out_ready_i(s_ordy), .out_data_o(s_od), .flush_i(1'b0),
        .a_o(s_a), .b_o(s_b), .c_o(s_c), .d_o(s_d), .occupancy_o(s_occ), .state_o(s_st),
        .stall_cnt_o(s_sc)
    );

    typedef struct {
        logic        iv;
        logic [31:0] din;
        logic        ordy;
        logic        fl;
        logic        e_ir;
        logic        e_ov;
        logic [31:0] e_d;
        logic [31:0] e_a;
        logic [2:0]  e_occ;
        logic [1:0]  e_st;
        logic [15:0] e_sc;
    } vec_t;

    localparam int N = 30;
    vec_t vec [N];

    function automatic vec_t mk(input logic i_v, input int i_d, input logic o_r, input logic f,
                                input logic e_ir, input logic e_ov, input int e_d, input int e_a,
                                input int e_occ, input int e_st, input int e_sc);
        vec_t r;
        r.iv = i_v; r.din = i_d; r.ordy = o_r; r.fl = f;
        r.e_ir = e_ir; r.e_ov = e_ov; r.e_d = e_d; r.e_a = e_a;
        r.e_occ = 3'(e_occ); r.e_st = 2'(e_st); r.e_sc = 16'(e_sc);
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        //            iv din    ordy fl | ir ov d   a   occ st sc
        vec[0]  = mk(1, 1,     1, 0,   1, 0, 0,  1,  1, 1, 0);
        vec[1]  = mk(1, 2,     1, 0,   1, 0, 0,  2,  2, 1, 0);
        vec[2]  = mk(1, 3,     1, 0,   1, 0, 0,  3,  3, 1, 0);
        vec[3]  = mk(1, 4,     1, 0,   1, 1, 1,  4,  4, 2, 0);
        vec[4]  = mk(1, 5,     1, 0,   1, 1, 2,  5,  4, 2, 0);
        vec[5]  = mk(1, 6,     1, 0,   1, 1, 3,  6,  4, 2, 0);
        vec[6]  = mk(1, 7,     1, 0,   1, 1, 4,  7,  4, 2, 0);
        vec[7]  = mk(1, 8,     1, 0,   1, 1, 5,  8,  4, 2, 0);
        vec[8]  = mk(1, 9,     0, 0,   0, 1, 5,  8,  4, 2, 1);
        vec[9]  = mk(1, 9,     0, 0,   0, 1, 5,  8,  4, 2, 2);
        vec[10] = mk(1, 9,     0, 0,   0, 1, 5,  8,  4, 2, 3);
        vec[11] = mk(1, 9,     1, 0,   1, 1, 6,  9,  4, 2, 3);
        vec[12] = mk(0, 0,     1, 0,   1, 1, 7,  9,  3, 2, 3);
        vec[13] = mk(0, 0,     1, 0,   1, 1, 8,  9,  2, 2, 3);
        vec[14] = mk(0, 0,     1, 0,   1, 1, 9,  9,  1, 2, 3);
        vec[15] = mk(0, 0,     1, 0,   1, 0, 9,  9,  0, 0, 3);
        vec[16] = mk(1, 10,    1, 0,   1, 0, 9,  10, 1, 1, 3);
        vec[17] = mk(0, 'h77,  1, 0,   1, 0, 9,  10, 1, 1, 3);
        vec[18] = mk(1, 11,    1, 0,   1, 0, 9,  11, 2, 1, 3);
        vec[19] = mk(0, 0,     1, 0,   1, 1, 10, 11, 2, 2, 3);
        vec[20] = mk(0, 0,     1, 0,   1, 0, 10, 11, 1, 1, 3);
        vec[21] = mk(0, 0,     1, 0,   1, 1, 11, 11, 1, 2, 3);
        vec[22] = mk(0, 0,     1, 0,   1, 0, 11, 11, 0, 0, 3);
        vec[23] = mk(1, 20,    1, 0,   1, 0, 11, 20, 1, 1, 3);
        vec[24] = mk(1, 21,    1, 0,   1, 0, 11, 21, 2, 1, 3);
        vec[25] = mk(1, 22,    1, 0,   1, 0, 11, 22, 3, 1, 3);
        vec[26] = mk(1, 23,    1, 0,   1, 1, 20, 23, 4, 2, 3);
        vec[27] = mk(1, 24,    0, 0,   0, 1, 20, 23, 4, 2, 4);
        vec[28] = mk(1, 25,    0, 1,   0, 0, 20, 23, 0, 0, 4);
        vec[29] = mk(0, 0,     1, 0,   1, 0, 20, 23, 0, 0, 4);

        rst_n = 1'b0; iv = 1'b0; din = '0; ordy = 1'b1; fl = 1'b0;
        s_iv = 1'b0; s_din = '0; s_ordy = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset out_valid", 32'(ov), 0);
        chk("reset in_ready", 32'(ir), 0);
        chk("reset occupancy", 32'(occ), 0);
        chk("reset state", 32'(st), 0);
        chk("reset stall_cnt", 32'(sc), 0);
        chk("reset d", d, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < N; k++) begin
            @(negedge clk);
            iv = vec[k].iv; din = vec[k].din; ordy = vec[k].ordy; fl = vec[k].fl;
            #1;
            chk($sformatf("row%0d in_ready", k), 32'(ir), 32'(vec[k].e_ir));
            @(posedge clk);
            #1;
            chk($sformatf("row%0d out_valid", k), 32'(ov), 32'(vec[k].e_ov));
            chk($sformatf("row%0d out_data", k), od, vec[k].e_d);
            chk($sformatf("row%0d a", k), a, vec[k].e_a);
            chk($sformatf("row%0d occupancy", k), 32'(occ), 32'(vec[k].e_occ));
            chk($sformatf("row%0d state", k), 32'(st), 32'(vec[k].e_st));
            chk($sformatf("row%0d stall_cnt", k), 32'(sc), 32'(vec[k].e_sc));
        end

        // Async reset in the middle of a full stream, checked before any clock edge
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            iv = 1'b1; din = 32'(50 + k); ordy = 1'b1; fl = 1'b0;
        end
        @(posedge clk);
        #1;
        chk("pre-reset out_valid", 32'(ov), 1);
        chk("pre-reset occupancy", 32'(occ), 4);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async out_valid", 32'(ov), 0);
        chk("async in_ready", 32'(ir), 0);
        chk("async occupancy", 32'(occ), 0);
        chk("async state", 32'(st), 0);
        chk("async a", a, 0);
        chk("async b", b, 0);
        chk("async c", c, 0);
        chk("async d", d, 0);
        iv = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Saturation of the 4-bit stall counter
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            s_iv = 1'b1; s_din = 32'(100 + k); s_ordy = 1'b1;
        end
        @(posedge clk);
        #1;
        chk("sat out_valid", 32'(s_ov), 1);
        chk("sat out_data", s_od, 100);
        @(negedge clk);
        s_ordy = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (k == 14) chk("sat cnt14", 32'(s_sc), 14);
            if (k == 15) chk("sat cnt15", 32'(s_sc), 15);
            if (k == 20) chk("sat cnt20", 32'(s_sc), 15);
        end
        chk("sat hold out_data", s_od, 100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
